trigger_window_capture: RTL and testbench
=========================================

TRIGGER_WINDOW_CAPTURE -- requirements
Module: trigger_window_capture

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one detector sample word.
REQ-002 Parameter DEPTH, default 64, ring buffer depth in words; power of two, SHALL satisfy DEPTH >= PRE_SAMPLES+POST_SAMPLES.
REQ-003 Parameter PRE_SAMPLES, default 16, samples kept before trigger.
REQ-004 Parameter POST_SAMPLES, default 32, samples captured from trigger onward.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 aresetn  input  1  reset, asynchronous, active-low.
REQ-007 trigger_i  input  1  single-cycle trigger pulse from the trigger emitter.
REQ-008 s_data_i  input  DATA_WIDTH  incoming sample word.
REQ-009 s_valid_i  input  1  s_data_i valid this cycle; no backpressure upstream.
REQ-010 m_data_o  output  DATA_WIDTH  readout word.
REQ-011 m_valid_o  output  1  m_data_o valid.
REQ-012 m_ready_i  input  1  downstream accepts; transfer when m_valid_o && m_ready_i.
REQ-013 m_last_o  output  1  marks final word of window.
REQ-014 busy_o  output  1  high whenever state != ARMED_IDLE or pre-fill incomplete.
REQ-015 dropped_o  output  16  saturating count of rejected triggers.

Function
REQ-016 FSM states SHALL be FILL, ARMED, POST, READOUT.
REQ-017 FILL: every s_valid_i writes s_data_i at wr_ptr, wr_ptr increments mod DEPTH, fill_cnt increments; at fill_cnt == PRE_SAMPLES SHALL go ARMED.
REQ-018 ARMED: sample writes continue; trigger_i SHALL latch trig_ptr = wr_ptr of that cycle and go POST; a sample valid in the trigger cycle is post-sample 0.
REQ-019 POST: writes continue, post_cnt counts written samples; after POST_SAMPLES writes (including trigger-cycle sample) SHALL go READOUT; writes stop.
REQ-020 READOUT: SHALL stream PRE_SAMPLES+POST_SAMPLES words from address trig_ptr-PRE_SAMPLES (mod DEPTH) ascending, wrapping at DEPTH.
REQ-021 Incoming samples during READOUT SHALL be discarded.
REQ-022 m_data_o/m_valid_o SHALL be registered; first m_valid_o no later than 2 cycles after entering READOUT.
REQ-023 m_valid_o held, m_data_o/m_last_o stable, while m_ready_i low.
REQ-024 With m_ready_i held high, one word per cycle after first, no bubbles.
REQ-025 m_last_o high only with word PRE_SAMPLES+POST_SAMPLES-1.
REQ-026 After last handshake SHALL go FILL with fill_cnt = 0 (re-arm requires PRE_SAMPLES fresh samples).
REQ-027 trigger_i in FILL, POST or READOUT SHALL be ignored and increment dropped_o, saturating at 16'hFFFF.
REQ-028 trigger_i coincident with the final handshake SHALL be dropped.
REQ-029 Pointers and counters SHALL wrap mod DEPTH by natural width $clog2(DEPTH).

Reset
REQ-030 Reset SHALL force FILL, wr_ptr=0, fill_cnt=0, post_cnt=0, m_valid_o=0, m_last_o=0, m_data_o=0, dropped_o=0, busy_o=1.
REQ-031 Reset mid-POST or mid-READOUT SHALL abort the window with no further m_valid_o.
REQ-032 Buffer RAM contents need no reset.

Structure
REQ-033 Shared package SHALL hold the FSM state enum and default DATA_WIDTH/DEPTH/PRE/POST constants.
REQ-034 Ring buffer SHALL be sub-module daq_ring_ram: simple dual-port, synchronous 1-cycle read, inferable as BRAM.

Verification
REQ-035 Reset, 16 samples 0..15 then trigger with sample 16, samples 17..47, ready high -> 48 words 0..47 contiguous, m_last_o on 47.
REQ-036 Trigger after 10 samples -> no capture, dropped_o=1, still FILL until sample 16.
REQ-037 Feed 100 samples (wrap), trigger at value 100, 31 more -> output 84..131, correct across address wrap.
REQ-038 m_ready_i toggled 1/0 each cycle -> 48 words, data held stable during stall, no loss or duplicate.
REQ-039 Trigger pulses during POST and READOUT and on last handshake -> dropped_o=3, window unaffected.
REQ-040 aresetn low at READOUT word 20 -> m_valid_o=0 next cycle, dropped_o=0, new window correct after refill.

Source files
------------

// File: rtl/trigger_window_capture_pkg.sv
// -----------------------------------------------------------------------------
// trigger_window_capture_pkg
// Shared definitions for the trigger window capture block: default sizing
// constants and the capture FSM state encoding.
// -----------------------------------------------------------------------------
package trigger_window_capture_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_DEPTH        = 64;
  localparam int DEF_PRE_SAMPLES  = 16;
  localparam int DEF_POST_SAMPLES = 32;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    ARMED   = 2'd1,
    POST    = 2'd2,
    READOUT = 2'd3
  } state_e;

endpackage

// File: rtl/trigger_window_capture_ring_ram.sv
// -----------------------------------------------------------------------------
// daq_ring_ram
// Simple dual-port sample buffer: one write port, one read port with a
// registered (1-cycle) read, written so that it maps onto block RAM.
// Contents are not reset.
//
// Ports:
//   clk        rising-edge clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_addr_i  read address, data appears on rd_data_o one cycle later
//   rd_data_o  registered read data
// -----------------------------------------------------------------------------
module daq_ring_ram
  import trigger_window_capture_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/trigger_window_capture.sv
// -----------------------------------------------------------------------------
// trigger_window_capture
// Keeps a running ring buffer of detector samples. Once PRE_SAMPLES samples
// have been collected it arms; a trigger then captures POST_SAMPLES more
// samples (the trigger-cycle sample is the first of them) and the whole
// PRE+POST window is streamed out on a valid/ready interface, oldest first.
//
// Ports:
//   clk        rising-edge clock
//   aresetn    asynchronous active-low reset
//   trigger_i  single-cycle trigger pulse
//   s_data_i   incoming sample, qualified by s_valid_i (no backpressure)
//   m_data_o   readout word, qualified by m_valid_o, accepted by m_ready_i
//   m_last_o   final word of the window
//   busy_o     high unless armed and waiting for a trigger
//   dropped_o  saturating count of triggers that were not accepted
// -----------------------------------------------------------------------------
module trigger_window_capture
  import trigger_window_capture_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int PRE_SAMPLES  = DEF_PRE_SAMPLES,
  parameter int POST_SAMPLES = DEF_POST_SAMPLES
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  trigger_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic [15:0]           dropped_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int TOTAL = PRE_SAMPLES + POST_SAMPLES;

  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_SAMPLES);
  localparam logic [CW-1:0] PRE_CNT   = CW'(PRE_SAMPLES);
  localparam logic [CW-1:0] POST_CNT  = CW'(POST_SAMPLES);
  localparam logic [CW-1:0] TOTAL_CNT = CW'(TOTAL);
  localparam logic [CW-1:0] LAST_IDX  = CW'(TOTAL - 1);

  state_e                state_q,    state_d;
  logic [AW-1:0]         wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]         trig_ptr_q, trig_ptr_d;
  logic [AW-1:0]         rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]         fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]         post_cnt_q, post_cnt_d;
  logic [CW-1:0]         ld_cnt_q,   ld_cnt_d;
  logic [DATA_WIDTH-1:0] m_data_q,   m_data_d;
  logic                  m_valid_q,  m_valid_d;
  logic                  m_last_q,   m_last_d;
  logic [15:0]           dropped_q,  dropped_d;

  logic                  ram_wr_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  drop;
  logic                  load;

  daq_ring_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ring_ram (
    .clk       (clk),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (s_data_i),
    .rd_addr_i (rd_ptr_d),
    .rd_data_o (ram_rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    post_cnt_d = post_cnt_q;
    ld_cnt_d   = ld_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    dropped_d  = dropped_q;
    drop       = 1'b0;
    load       = 1'b0;

    // The buffer is frozen while the window is being read out.
    ram_wr_en = s_valid_i && (state_q != READOUT);
    if (ram_wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    unique case (state_q)
      FILL: begin
        drop = trigger_i;
        if (s_valid_i) begin
          fill_cnt_d = fill_cnt_q + CW'(1);
          if (fill_cnt_d == PRE_CNT) begin
            state_d = ARMED;
          end
        end
      end

      ARMED: begin
        if (trigger_i) begin
          trig_ptr_d = wr_ptr_q;
          // A sample arriving with the trigger is post-sample 0.
          post_cnt_d = {{(CW-1){1'b0}}, s_valid_i};
          state_d    = (post_cnt_d == POST_CNT) ? READOUT : POST;
        end
      end

      POST: begin
        drop = trigger_i;
        if (s_valid_i) begin
          post_cnt_d = post_cnt_q + CW'(1);
          if (post_cnt_d == POST_CNT) begin
            state_d = READOUT;
          end
        end
      end

      READOUT: begin
        drop = trigger_i;
        // Refill the output register whenever it is empty or being drained.
        // The RAM read port always addresses the word the next load will
        // take, so a stall simply keeps re-reading the same address.
        load = (ld_cnt_q != TOTAL_CNT) && (!m_valid_q || m_ready_i);
        if (load) begin
          m_data_d  = ram_rd_data;
          m_valid_d = 1'b1;
          m_last_d  = (ld_cnt_q == LAST_IDX);
          ld_cnt_d  = ld_cnt_q + CW'(1);
          rd_ptr_d  = rd_ptr_q + AW'(1);
        end else if (m_valid_q && m_ready_i) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
        if (m_valid_q && m_ready_i && m_last_q) begin
          state_d    = FILL;
          fill_cnt_d = '0;
          post_cnt_d = '0;
        end
      end

      default: state_d = FILL;
    endcase

    // Outside readout, keep the read address parked on the window start so
    // the first word is already in the RAM output register on entry.
    if (state_q != READOUT) begin
      rd_ptr_d = trig_ptr_d - PRE_OFS;
      ld_cnt_d = '0;
    end

    if (drop && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      post_cnt_q <= '0;
      ld_cnt_q   <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      post_cnt_q <= post_cnt_d;
      ld_cnt_q   <= ld_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      dropped_q  <= dropped_d;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;
  assign busy_o    = (state_q != ARMED);
  assign dropped_o = dropped_q;

endmodule

// File: tb/tb_trigger_window_capture.sv
// -----------------------------------------------------------------------------
// tb_trigger_window_capture
// Directed bench: a table of capture windows (pre-trigger length, first
// sample value, ready pattern, expected first output word) plus hand-written
// sequences for early triggers, dropped triggers and reset during readout.
// -----------------------------------------------------------------------------
module tb_trigger_window_capture;

  localparam int DW   = 16;
  localparam int WIN  = 48;
  localparam int POST = 32;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          trigger_i;
  logic [DW-1:0] s_data_i;
  logic          s_valid_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          m_last_o;
  logic          busy_o;
  logic [15:0]   dropped_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int pre_n;      // samples fed before the trigger sample
    int base;       // value of the first sample fed
    bit stall;      // toggle m_ready_i every cycle
    int exp_first;  // expected first word of the window
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  trigger_window_capture dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .trigger_i (trigger_i),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_last_o  (m_last_o),
    .busy_o    (busy_o),
    .dropped_o (dropped_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    trigger_i = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    m_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  // Feed n consecutive samples starting at base; trigger_i rides along with
  // sample index trig_idx and extra_idx (-1 = none).
  task automatic feed(input int base, input int n, input int trig_idx, input int extra_idx);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid_i = 1'b1;
      s_data_i  = DW'(base + i);
      trigger_i = (i == trig_idx) || (i == extra_idx);
    end
    @(negedge clk);
    s_valid_i = 1'b0;
    trigger_i = 1'b0;
  endtask

  // Drain a window, checking each accepted word and its last flag. Optional
  // trigger pulse alongside handshake trig_word and/or the final handshake;
  // abort_at >= 0 asserts reset instead of accepting that word.
  task automatic collect(input int exp_first, input bit stall, input int trig_word,
                         input bit trig_last, input int abort_at);
    int            got_n;
    int            cyc;
    bit            held;
    bit            rdy;
    logic [DW+1:0] held_val;
    got_n = 0;
    cyc   = 0;
    held  = 1'b0;
    rdy   = 1'b0;
    held_val = '0;
    while (got_n < WIN && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      trigger_i = 1'b0;
      if (held) begin
        chk("stall_hold", {14'd0, m_valid_o, m_last_o, m_data_o}, {14'd0, held_val});
        held = 1'b0;
      end
      rdy       = stall ? ~rdy : 1'b1;
      m_ready_i = rdy;
      if (m_valid_o) begin
        if (!rdy) begin
          held     = 1'b1;
          held_val = {1'b1, m_last_o, m_data_o};
        end else if (got_n == abort_at) begin
          aresetn = 1'b0;
          @(negedge clk);
          chk("abort_valid", 32'(m_valid_o), 32'd0);
          chk("abort_dropped", 32'(dropped_o), 32'd0);
          chk("abort_busy", 32'(busy_o), 32'd1);
          aresetn   = 1'b1;
          m_ready_i = 1'b0;
          return;
        end else begin
          chk("word", 32'(m_data_o), 32'(exp_first + got_n));
          chk("last", 32'(m_last_o), 32'(got_n == WIN - 1));
          if (got_n == trig_word || (trig_last && got_n == WIN - 1)) trigger_i = 1'b1;
          got_n++;
        end
      end
    end
    if (got_n < WIN) chk("timeout_words", 32'(got_n), 32'(WIN));
    @(negedge clk);
    trigger_i = 1'b0;
    m_ready_i = 1'b0;
    chk("idle_valid", 32'(m_valid_o), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd1);
  endtask

  initial begin
    vecs[0] = '{pre_n: 16, base: 0,    stall: 1'b0, exp_first: 0};
    vecs[1] = '{pre_n: 100, base: 0,   stall: 1'b0, exp_first: 84};
    vecs[2] = '{pre_n: 16, base: 0,    stall: 1'b1, exp_first: 0};
    vecs[3] = '{pre_n: 30, base: 1000, stall: 1'b0, exp_first: 1014};
    vecs[4] = '{pre_n: 64, base: 500,  stall: 1'b1, exp_first: 548};

    // Reset state
    aresetn   = 1'b0;
    trigger_i = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    m_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_last", 32'(m_last_o), 32'd0);
    chk("rst_data", 32'(m_data_o), 32'd0);
    chk("rst_dropped", 32'(dropped_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd1);
    aresetn = 1'b1;

    // Table of capture windows
    for (int v = 0; v < 5; v++) begin
      do_reset();
      feed(vecs[v].base, vecs[v].pre_n + POST, vecs[v].pre_n, -1);
      collect(vecs[v].exp_first, vecs[v].stall, -1, 1'b0, -1);
      chk("vec_dropped", 32'(dropped_o), 32'd0);
    end

    // Early trigger while filling is dropped and does not arm
    do_reset();
    feed(0, 10, -1, -1);
    @(negedge clk);
    trigger_i = 1'b1;
    @(negedge clk);
    trigger_i = 1'b0;
    chk("early_dropped", 32'(dropped_o), 32'd1);
    chk("early_busy", 32'(busy_o), 32'd1);
    feed(10, 5, -1, -1);
    chk("fill15_busy", 32'(busy_o), 32'd1);
    feed(15, 1, -1, -1);
    chk("fill16_busy", 32'(busy_o), 32'd0);
    feed(16, POST, 0, -1);
    collect(0, 1'b0, -1, 1'b0, -1);
    chk("early_dropped_end", 32'(dropped_o), 32'd1);

    // Triggers during POST, READOUT and on the final handshake
    do_reset();
    feed(0, WIN, 16, 20);
    collect(0, 1'b0, 10, 1'b1, -1);
    chk("drop3", 32'(dropped_o), 32'd3);

    // Reset in the middle of readout, then a fresh window
    do_reset();
    feed(0, WIN, 16, -1);
    collect(0, 1'b0, -1, 1'b0, 20);
    feed(200, WIN, 16, -1);
    collect(200, 1'b0, -1, 1'b0, -1);
    chk("after_abort_dropped", 32'(dropped_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
